// File: rtl/exe_mem.sv
// -----------------------------------------------------------------------------
// exe_mem -- EX/MEM pipeline register of the 5-stage RV32I core.
//
// Latches the execute-stage results and the memory-access controls consumed by
// the mem stage. It also owns two pieces of stall logic:
//   * a memory access is held stable for MEM_LAT cycles, and stall_req_o asks
//     ctrl to freeze the front of the pipeline while the access completes;
//   * misaligned halfword/word accesses are squashed into a bubble. The op is
//     kept on mem_ctrl_o so the squashed access is still visible for debug.
//
// Parameters:
//   MEM_LAT  data-memory latency in cycles (1..15); 1 never stalls
//   OP_W     width of the mem_ctrl op field (matches the shared op defines)
//
// Ports:
//   clk_i        in   1     clock, rising edge
//   rst_i        in   1     asynchronous, active-high reset
//   stall_i      in   1     external stall from ctrl (freeze)
//   flush_i      in   1     flush from ctrl (load a bubble)
//   mem_ctrl_i   in   OP_W  memory op from exe (0 = NOP)
//   reg_waddr_i  in   5     destination register
//   reg_we_i     in   1     register write enable
//   reg_wdata_i  in   32    ALU result, or store data for stores
//   mem_addr_i   in   32    effective memory address
//   mem_we_i     in   1     store request
//   mem_re_i     in   1     load request
//   *_o          out  same  registered copies of the inputs above, to mem
//   stall_req_o  out  1     high while a multi-cycle access is in progress
//   misalign_o   out  1     one-cycle pulse when a misaligned access was squashed
// -----------------------------------------------------------------------------
module exe_mem #(
    parameter int MEM_LAT = 1,
    parameter int OP_W    = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [OP_W-1:0] mem_ctrl_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            reg_we_i,
    input  logic [31:0]     reg_wdata_i,
    input  logic [31:0]     mem_addr_i,
    input  logic            mem_we_i,
    input  logic            mem_re_i,
    output logic [OP_W-1:0] mem_ctrl_o,
    output logic [4:0]      reg_waddr_o,
    output logic            reg_we_o,
    output logic [31:0]     reg_wdata_o,
    output logic [31:0]     mem_addr_o,
    output logic            mem_we_o,
    output logic            mem_re_o,
    output logic            stall_req_o,
    output logic            misalign_o
);

    // Shared memory-op encodings (only the ones with alignment constraints
    // are needed here; byte ops and NOP can never be misaligned).
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

    // The capture edge itself is the first latency cycle and the return edge
    // BUSY->IDLE is the last, so the counter only covers what lies between.
    localparam bit         MULTI_CYCLE = (MEM_LAT > 1);
    localparam logic [3:0] CNT_INIT    = MULTI_CYCLE ? 4'(MEM_LAT - 2) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic            w_capture;
    logic            w_misalign;
    logic            w_mem_access;

    logic [OP_W-1:0] r_mem_ctrl;
    logic [4:0]      r_reg_waddr;
    logic            r_reg_we;
    logic [31:0]     r_reg_wdata;
    logic [31:0]     r_mem_addr;
    logic            r_mem_we;
    logic            r_mem_re;
    logic            r_misalign;

    function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                           input logic [1:0]      addr_lo);
        if (op == OP_SH || op == OP_LH || op == OP_LHU) begin
            return addr_lo[0];
        end else if (op == OP_SW || op == OP_LW) begin
            return (addr_lo != 2'b00);
        end
        return 1'b0;
    endfunction

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state is written with non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every register regardless of order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state, counter and capture decision
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_misalign   = is_misaligned(mem_ctrl_i, mem_addr_i[1:0]);
        w_mem_access = mem_we_i | mem_re_i;
        // A capture only happens in IDLE without an external stall; flush is
        // handled ahead of it in the datapath register.
        w_capture    = (r_state == S_IDLE) && !stall_i && !flush_i;

        if (flush_i) begin
            // Aborts any access in flight.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_capture && w_mem_access && MULTI_CYCLE && !w_misalign) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
                S_BUSY: begin
                    // Counts even under stall_i: memory latency does not care
                    // whether the pipeline is frozen.
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath register: reset > flush > hold > capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_ctrl  <= '0;
            r_reg_waddr <= '0;
            r_reg_we    <= 1'b0;
            r_reg_wdata <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (flush_i) begin
            r_mem_ctrl  <= '0;
            r_reg_waddr <= '0;
            r_reg_we    <= 1'b0;
            r_reg_wdata <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (w_capture) begin
            if (w_misalign) begin
                // Squash into a bubble but leave the op visible for debug.
                r_mem_ctrl  <= mem_ctrl_i;
                r_reg_waddr <= '0;
                r_reg_we    <= 1'b0;
                r_reg_wdata <= '0;
                r_mem_addr  <= '0;
                r_mem_we    <= 1'b0;
                r_mem_re    <= 1'b0;
                r_misalign  <= 1'b1;
            end else begin
                r_mem_ctrl  <= mem_ctrl_i;
                r_reg_waddr <= reg_waddr_i;
                r_reg_we    <= reg_we_i;
                r_reg_wdata <= reg_wdata_i;
                r_mem_addr  <= mem_addr_i;
                r_mem_we    <= mem_we_i;
                r_mem_re    <= mem_re_i;
                r_misalign  <= 1'b0;
            end
        end else begin
            // Hold: contents stay, the misalign pulse ends.
            r_misalign <= 1'b0;
        end
    end

    assign mem_ctrl_o  = r_mem_ctrl;
    assign reg_waddr_o = r_reg_waddr;
    assign reg_we_o    = r_reg_we;
    assign reg_wdata_o = r_reg_wdata;
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_re_o    = r_mem_re;
    assign misalign_o  = r_misalign;
    // Decoded from state alone so ctrl sees it in the same cycle, glitch-free.
    assign stall_req_o = (r_state == S_BUSY);

endmodule

// File: doc/exe_mem.md
Name: exe_mem

Overview:
- Pipeline register between the execute stage and the mem stage of the 5-stage RV32I core.
- Latches the execute results and the memory-access controls that the mem stage consumes.
- Also decides on stalls:
  - Holds a memory access stable for MEM_LAT cycles and requests a pipeline stall from ctrl while it waits.
  - Flags misaligned halfword/word accesses and squashes them.

Parameters:
- MEM_LAT, 1: data-memory access latency in cycles, legal range 1..15. A value of 1 means no stall is generated.
- OP_W, 8: width of the mem_ctrl op field. Must match the shared op-define width.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- stall_i  input  1  from ctrl; freeze this register (external stall)
- flush_i  input  1  from ctrl; replace contents with a bubble
- mem_ctrl_i  input  OP_W  op from exe (SB/SH/SW/LB/LH/LW/LBU/LHU/other)
- reg_waddr_i  input  5  destination register
- reg_we_i  input  1  register write enable
- reg_wdata_i  input  32  ALU result, or store data for stores
- mem_addr_i  input  32  effective memory address
- mem_we_i  input  1  store request
- mem_re_i  input  1  load request
- mem_ctrl_o, reg_waddr_o, reg_we_o, reg_wdata_o, mem_addr_o, mem_we_o, mem_re_o  output  (same widths)  registered copies sent to mem
- stall_req_o  output  1  to ctrl; high while a multi-cycle access is in progress
- misalign_o  output  1  to ctrl; one-cycle pulse when a misaligned access was squashed

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - All outputs go to 0; mem_ctrl_o goes to 0 (the NOP encoding).
  - FSM goes to IDLE; counter goes to 0.
- Bubble means: all data/control outputs are 0, reg_we_o = 0, mem_we_o = 0, mem_re_o = 0.
- Update priority at each rising edge:
  1. rst_i
  2. flush_i
  3. hold, when state == BUSY or stall_i == 1
  4. capture
- Capture rule: all *_i inputs are registered to *_o. Latency is 1 cycle.
- Misalignment check, applied at capture:
  - Misaligned means:
    - SH, LH or LHU with mem_addr_i[0] == 1, or
    - SW or LW with mem_addr_i[1:0] != 0.
  - On a misaligned access:
    - A bubble is loaded, except mem_ctrl_o, which keeps the op for debug visibility.
    - misalign_o = 1 for exactly that one cycle.
    - The FSM stays in IDLE.
  - misalign_o is 0 on every other edge.
- FSM states are IDLE and BUSY. The counter cnt is 4 bits.
  - IDLE -> BUSY: at a capture edge where (mem_we_i | mem_re_i) == 1, MEM_LAT > 1 and the access is not misaligned. At that edge cnt is loaded with MEM_LAT-2.
  - BUSY with cnt != 0: cnt decrements each edge.
  - BUSY with cnt == 0: the next edge returns to IDLE. That edge is not a capture edge; the outputs still hold.
  - stall_req_o = (state == BUSY). It is combinational from state only.
  - Result: stall_req_o is high for exactly MEM_LAT-1 cycles after the capture edge. The outputs stay stable for MEM_LAT cycles total.
- stall_i while BUSY: cnt keeps counting, because the memory latency is independent of the pipeline stall. Outputs hold.
- stall_i while IDLE: outputs hold; no capture occurs.
- flush_i while BUSY: the access is aborted. Bubble loaded, state goes to IDLE, cnt = 0, stall_req_o drops in the next cycle.
- flush_i and stall_i together: flush wins.
- A back-to-back memory op arriving on the edge that returns BUSY -> IDLE is not captured. Ctrl must keep it in exe, which it does because stall_req_o was high on that cycle.
- Non-memory ops never enter BUSY, regardless of MEM_LAT.

Test Plan:
1. Reset: assert rst_i asynchronously mid-cycle with all inputs non-zero -> every output is 0 immediately, before the next clock edge; stall_req_o = 0.
2. ALU op passthrough, MEM_LAT = 3: reg_waddr_i = 5, reg_we_i = 1, reg_wdata_i = 0xDEADBEEF, mem_we_i = mem_re_i = 0 -> values appear one cycle later; stall_req_o stays 0.
3. LW at 0x100, MEM_LAT = 3:
   - mem_re_o = 1 and mem_addr_o = 0x100 held for 3 cycles.
   - stall_req_o high for exactly 2 cycles.
   - A new input is captured on the 4th edge.
4. SH at 0x103 -> squashed: reg_we_o = 0, mem_we_o = 0, mem_re_o = 0, mem_ctrl_o = SH, misalign_o high for 1 cycle, stall_req_o = 0. LW at 0x102 gives the same squash. LB at 0x103 passes normally.
5. Flush during BUSY, MEM_LAT = 4: SW captured, flush_i asserted on the 2nd cycle -> bubble at the next edge; stall_req_o low from the following cycle; the next op is captured normally.
6. stall_i = 1 during BUSY, MEM_LAT = 3: stall_req_o still falls after 2 cycles. Outputs hold while stall_i = 1. Capture resumes on the first edge with stall_i = 0 and state IDLE.
